clock_mode_ctrl: RTL

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

---
 rtl/clock_mode_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode/adjust sequencer for a clock display: 1 Hz run tick, field-select set
// states with press/auto-repeat adjust pulses and an idle timeout back to RUN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | counters advance on the 1 Hz tick, adjust buttons ignored
// SET_HOUR | hour field selected, up/down produce adjust ticks
// SET_MIN  | minute field selected, up/down produce adjust ticks
// SET_SEC  | second field selected, up/down produce adjust ticks
module clock_mode_ctrl #(
  parameter int DIV     = 50_000_000,
  parameter int HOLD    = 25_000_000,
  parameter int REPEAT  = 6_250_000,
  parameter int TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       display,
  output logic       setup_hour,
  output logic       setup_minute,
  output logic       setup_second,
  output logic       inc_dec,
  output logic       tick,
  output logic [1:0] mode
);

  localparam int PW = $clog2(DIV);
  localparam int HW = $clog2(HOLD + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] PRE_LAST    = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - REPEAT);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [IW-1:0] IDLE_LIM    = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          primed_q;
  logic          mode_prev_q, up_prev_q, down_prev_q;
  logic          tick_d, inc_dec_d;

  logic edge_mode, edge_up, edge_down;
  logic sec_pulse, in_set, timeout_hit, state_change;
  logic one_btn, adjust_ok, adj_edge, rep_hit, tick_cand;

  always_comb begin
    // primed_q masks edges on the first edge after reset so a held button
    // has to be released and pressed again
    edge_mode = primed_q & btn_mode & ~mode_prev_q;
    edge_up   = primed_q & btn_up   & ~up_prev_q;
    edge_down = primed_q & btn_down & ~down_prev_q;

    sec_pulse = (presc_q == PRE_LAST);
    presc_d   = sec_pulse ? '0 : presc_q + PW'(1);

    in_set       = (state_q != RUN);
    timeout_hit  = in_set & (idle_q == IDLE_LIM);
    state_change = timeout_hit | edge_mode;

    one_btn   = btn_up ^ btn_down;
    adjust_ok = in_set & ~state_change & one_btn;
    adj_edge  = adjust_ok & (edge_up | edge_down);
    rep_hit   = adjust_ok & ~adj_edge & (hold_q == HOLD_LAST);

    state_d = state_q;
    if (timeout_hit) begin
      state_d = RUN;
    end else if (edge_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end

    // hold_q == 0 means no press is being tracked
    hold_d = '0;
    if (adjust_ok) begin
      if (adj_edge)
        hold_d = HOLD_ONE;
      else if (hold_q == '0)
        hold_d = '0;
      else if (rep_hit)
        hold_d = HOLD_RELOAD;
      else
        hold_d = hold_q + HW'(1);
    end

    idle_d = idle_q;
    if (!in_set || state_change || edge_up || edge_down || rep_hit)
      idle_d = '0;
    else if (sec_pulse)
      idle_d = idle_q + IW'(1);

    // back-to-back candidates (e.g. run tick then an immediate press) are
    // dropped so tick stays a clean single-cycle pulse
    tick_cand = in_set ? (adj_edge | rep_hit) : sec_pulse;
    tick_d    = tick_cand & ~tick;
    inc_dec_d = (in_set & tick_d) ? btn_up : inc_dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      presc_q      <= '0;
      hold_q       <= '0;
      idle_q       <= '0;
      primed_q     <= 1'b0;
      mode_prev_q  <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
      tick         <= 1'b0;
      inc_dec      <= 1'b1;
      mode         <= 2'd0;
      display      <= 1'b0;
      setup_hour   <= 1'b1;
      setup_minute <= 1'b1;
      setup_second <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      idle_q       <= idle_d;
      primed_q     <= 1'b1;
      mode_prev_q  <= btn_mode;
      up_prev_q    <= btn_up;
      down_prev_q  <= btn_down;
      tick         <= tick_d;
      inc_dec      <= inc_dec_d;
      mode         <= state_d;
      display      <= (state_d != RUN);
      setup_hour   <= (state_d != SET_HOUR);
      setup_minute <= (state_d != SET_MIN);
      setup_second <= (state_d != SET_SEC);
    end
  end

endmodule
